// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART command parser and telemetry responder.
// Decodes single- and multi-byte commands from the uart_top receive stream,
// keeps a bank of 8-bit control registers, counts camera frames on a
// synchronised VSYNC rising edge, and returns replies over a valid/ready
// transmit handshake.
module uart_cmd_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 270000
) (
  input  logic                     sys_clk,
  input  logic                     sys_resetn,
  input  logic                     cam_vsync,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_REGS*8-1:0]    ctrl_regs,
  output logic                     sobel_enable,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [7:0]               drop_count
);

  // Parser states
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARG_ADDR = 2'd1;
  localparam logic [1:0] S_ARG_DATA = 2'd2;
  localparam logic [1:0] S_TX       = 2'd3;

  // Command and reply characters
  localparam logic [7:0] CH_READ_CNT = 8'h52;  // 'R'
  localparam logic [7:0] CH_SOBEL_ON = 8'h53;  // 'S'
  localparam logic [7:0] CH_SOBEL_OF = 8'h73;  // 's'
  localparam logic [7:0] CH_WRITE    = 8'h57;  // 'W'
  localparam logic [7:0] CH_GET      = 8'h47;  // 'G'
  localparam logic [7:0] CH_ACK      = 8'h4B;  // 'K'
  localparam logic [7:0] CH_ERR      = 8'h3F;  // '?'

  localparam int NBYTES = CNT_WIDTH / 8;
  localparam int AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);

  // VSYNC synchroniser and edge detector
  logic [SYNC_STAGES-1:0] r_vsync_sync;
  logic                   r_vsync_prev;
  logic                   w_vsync_rise;
  logic [CNT_WIDTH-1:0]   r_frame_cnt;

  // Parser state
  logic [1:0]             r_state;
  logic                   r_op_write;
  logic [AW-1:0]          r_addr;
  logic [TW-1:0]          r_to_cnt;
  logic [CNT_WIDTH-1:0]   r_tx_shift;
  logic [2:0]             r_tx_left;
  logic [7:0]             r_regs [NUM_REGS];
  logic [7:0]             r_drop;

  // Combinational helpers
  logic                   w_in_arg;
  logic                   w_timeout;
  logic [1:0]             w_state_eff;
  logic                   w_addr_ok;
  logic [7:0]             w_rd_byte;

  // Place a single reply byte in the top byte of the tx shift register,
  // which is where tx_data is taken from.
  function automatic logic [CNT_WIDTH-1:0] f_reply_byte(input logic [7:0] b);
    return CNT_WIDTH'(b) << (CNT_WIDTH - 8);
  endfunction

  // Saturating increment for the dropped-byte counter.
  function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_vsync_rise = r_vsync_sync[SYNC_STAGES-1] & ~r_vsync_prev;

  // Synchronise the asynchronous VSYNC into the sys_clk domain
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_vsync_sync <= '0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_vsync_sync <= {r_vsync_sync[SYNC_STAGES-2:0], cam_vsync};
      r_vsync_prev <= r_vsync_sync[SYNC_STAGES-1];
    end
  end

  // Count one frame per synchronised VSYNC rising edge, wrapping naturally
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_frame_cnt <= '0;
    end else if (w_vsync_rise) begin
      r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
    end
  end

  // A timeout in an argument state behaves as if the parser were already
  // idle, so a byte arriving in that very cycle is decoded as a command.
  assign w_in_arg    = (r_state == S_ARG_ADDR) || (r_state == S_ARG_DATA);
  assign w_timeout   = w_in_arg && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_state_eff = w_timeout ? S_IDLE : r_state;
  assign w_addr_ok   = (32'(rx_data) < NUM_REGS);
  assign w_rd_byte   = r_regs[rx_data[AW-1:0]];

  // Command parser, register bank, reply sequencing and drop counting
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state    <= S_IDLE;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_to_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_left  <= '0;
      r_drop     <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      if (w_in_arg) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (w_timeout) begin
        r_state <= S_IDLE;
      end

      case (w_state_eff)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CH_READ_CNT: begin
                // The registered count is the pre-increment value even
                // when a VSYNC edge lands in this same cycle.
                r_tx_shift <= r_frame_cnt;
                r_tx_left  <= 3'(NBYTES);
                r_state    <= S_TX;
              end
              CH_SOBEL_ON: begin
                r_regs[0][0] <= 1'b1;
                r_tx_shift   <= f_reply_byte(CH_ACK);
                r_tx_left    <= 3'd1;
                r_state      <= S_TX;
              end
              CH_SOBEL_OF: begin
                r_regs[0][0] <= 1'b0;
                r_tx_shift   <= f_reply_byte(CH_ACK);
                r_tx_left    <= 3'd1;
                r_state      <= S_TX;
              end
              CH_WRITE: begin
                r_op_write <= 1'b1;
                r_to_cnt   <= '0;
                r_state    <= S_ARG_ADDR;
              end
              CH_GET: begin
                r_op_write <= 1'b0;
                r_to_cnt   <= '0;
                r_state    <= S_ARG_ADDR;
              end
              default: begin
                r_tx_shift <= f_reply_byte(CH_ERR);
                r_tx_left  <= 3'd1;
                r_state    <= S_TX;
              end
            endcase
          end
        end

        S_ARG_ADDR: begin
          if (rx_valid) begin
            r_to_cnt <= '0;
            if (!w_addr_ok) begin
              r_tx_shift <= f_reply_byte(CH_ERR);
              r_tx_left  <= 3'd1;
              r_state    <= S_TX;
            end else if (r_op_write) begin
              r_addr  <= rx_data[AW-1:0];
              r_state <= S_ARG_DATA;
            end else begin
              r_tx_shift <= f_reply_byte(w_rd_byte);
              r_tx_left  <= 3'd1;
              r_state    <= S_TX;
            end
          end
        end

        S_ARG_DATA: begin
          if (rx_valid) begin
            r_to_cnt       <= '0;
            r_regs[r_addr] <= rx_data;
            r_tx_shift     <= f_reply_byte(CH_ACK);
            r_tx_left      <= 3'd1;
            r_state        <= S_TX;
          end
        end

        default: begin  // S_TX
          if (rx_valid) begin
            r_drop <= f_sat_inc8(r_drop);
          end
          if (tx_ready) begin
            r_tx_shift <= r_tx_shift << 8;
            r_tx_left  <= r_tx_left - 3'd1;
            if (r_tx_left == 3'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Flatten the register bank onto the output bus
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_regs
      assign ctrl_regs[8*g +: 8] = r_regs[g];
    end
  endgenerate

  assign tx_valid     = (r_state == S_TX);
  assign tx_data      = r_tx_shift[CNT_WIDTH-1 -: 8];
  assign sobel_enable = r_regs[0][0];
  assign frame_count  = r_frame_cnt;
  assign drop_count   = r_drop;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Parametrised UART command and telemetry controller. It sits between the `uart_top` byte streams and the video/Sobel control path. It decodes single-byte and multi-byte commands and maintains a bank of 8-bit control registers. It counts camera frames on a synchronised VSYNC rising edge and returns multi-byte responses over a valid/ready transmit handshake.

## Interface
- `CNT_WIDTH`, default 16: frame counter width; must be a multiple of 8 (8..32).
- `NUM_REGS`, default 4: number of 8-bit control registers (1..16).
- `SYNC_STAGES`, default 2: VSYNC synchroniser depth (≥2).
- `TIMEOUT`, default 270000: idle cycles allowed between command bytes (10 ms at 27 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk` in 1: system clock (27 MHz).
- `sys_resetn` in 1: asynchronous active-low reset.
- `cam_vsync` in 1: camera VSYNC, asynchronous to `sys_clk`.
- `rx_data` in 8: received byte from `uart_top`.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `ctrl_regs` out `NUM_REGS*8`: register bank; reg k occupies bits [8k+7:8k].
- `sobel_enable` out 1: equals reg0 bit 0.
- `frame_count` out `CNT_WIDTH`: live frame counter.
- `drop_count` out 8: saturating count of discarded rx bytes.

## Operation
- VSYNC path: `SYNC_STAGES`-flop synchroniser, then rising-edge detect. Each edge increments `frame_count` modulo 2^`CNT_WIDTH` (wraps from all-ones to 0). A level held high counts once.
- Parser states: IDLE, ARG_ADDR, ARG_DATA, TX.
- IDLE, on `rx_valid`:
  - `R` (0x52): snapshot `frame_count` into the tx shift register. Go to TX with `CNT_WIDTH/8` bytes, MSB first.
  - `S` (0x53): set reg0[0]. Reply `K` (0x4B).
  - `s` (0x73): clear reg0[0]. Reply `K`.
  - `W` (0x57): go to ARG_ADDR with op=write.
  - `G` (0x47): go to ARG_ADDR with op=read.
  - Any other byte: reply `?` (0x3F).
- ARG_ADDR, on `rx_valid`:
  - Address ≥ `NUM_REGS`: reply `?`.
  - op=read: reply with the register value (1 byte).
  - op=write: latch the address and go to ARG_DATA.
- ARG_DATA, on `rx_valid`: write the byte to the addressed register and reply `K`.
- Timeout: in ARG_ADDR or ARG_DATA, a counter restarts on every entry and on every rx byte. After `TIMEOUT` cycles with no byte, return to IDLE with no reply and no register change.
- TX: present bytes in order. Return to IDLE after the last byte handshakes.
  - Any `rx_valid` during TX is discarded and increments `drop_count`, which saturates at 255.
  - Only reset clears `drop_count`.
- `R` snapshot: if a VSYNC edge increments the counter in the same cycle as the `R` accept, the snapshot holds the pre-increment value.
- Reset values: `ctrl_regs`=0, `sobel_enable`=0, `frame_count`=0, `drop_count`=0, `tx_valid`=0, `tx_data`=0. The synchroniser resets to 0, so a high VSYNC at reset release produces one edge.
- Reset asserted mid-command or mid-response aborts immediately. State returns to IDLE, `tx_valid` drops asynchronously, and no partial register write occurs.

## Timing
- Command accepted at edge N: `tx_valid`=1 with the first byte from edge N+1 (1-cycle latency). The same applies to the final argument byte of `W`/`G`.
- Register writes from `S`/`s`/`W` are visible on `ctrl_regs` at edge N+1.
- Handshake: `tx_data` holds stable while `tx_valid`=1 and `tx_ready`=0.
  - After a handshake at edge M that is not the last byte, the next byte appears at edge M+1 and `tx_valid` stays high.
  - After the last byte's handshake, `tx_valid`=0 from edge M+1.
- Back-to-back bytes with `tx_ready` held high: one byte per cycle.
- `frame_count` updates on the (`SYNC_STAGES`+1)th `sys_clk` rising edge after `cam_vsync` rises, given setup is met.
- Timeout fires exactly `TIMEOUT` cycles after the last accepted byte. A byte arriving in that same cycle is treated as timed-out and is parsed from IDLE.

## Test plan
- Frame count: reset, then 3 VSYNC pulses, then send `R` with `tx_ready`=1. Required: bytes 0x00, 0x03 on consecutive cycles, then `tx_valid`=0. With `CNT_WIDTH`=8, preload 255 pulses plus 1 and send `R`: reply 0x00 (wrap).
- Register write/read:
  - `W`,0x02,0xA5 → reply 0x4B and `ctrl_regs`[23:16]=0xA5.
  - `G`,0x02 → reply 0xA5.
  - `G`,0x04 (`NUM_REGS`=4) → reply 0x3F with no register changes.
- Sobel control:
  - `S` → `sobel_enable`=1 one cycle after accept, reply 0x4B.
  - `s` → 0.
  - Unknown byte 0x41 → reply 0x3F.
- Backpressure and drop: send `R`, hold `tx_ready`=0 for 20 cycles, inject 3 rx bytes. Required: `tx_data` stable at the MSB throughout and `drop_count`=3. Then release `tx_ready`: both bytes delivered in order.
- Timeout (`TIMEOUT`=16): send `W`, then wait 16 idle cycles, then send `S`. Required: `S` is parsed as a command (reply 0x4B, reg0[0]=1), not as an address.
- Reset mid-response: assert `sys_resetn`=0 while the second `R` byte is pending. Required: `tx_valid`=0 immediately and all outputs at reset values. After release, `R` returns 0x00,0x00.
